// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I(+M) main control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared
// datapath with ready-handshaked memory, optional MUL/DIV wait, wait timeout and illegal trap.
module multicycle_controller #(
    parameter bit ENABLE_M     = 1'b1,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [6:0] funct7_i,
    input  logic       mem_ready_i,
    input  logic       muldiv_done_i,
    output logic [2:0] state_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       iord_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_op_o,
    output logic       alu_src_o,
    output logic       mem_to_reg_o,
    output logic       branch_o,
    output logic       jump_o,
    output logic       jalr_o,
    output logic       lui_o,
    output logic       auipc_o,
    output logic       muldiv_start_o,
    output logic       illegal_o,
    output logic       bus_fault_o
);

    localparam int TMO_W = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV, S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_MULDIV
    } cls_t;

    state_t           state_q, state_next;
    cls_t             cls_q, dec_cls;
    logic             dec_illegal;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic             illegal_q, bus_fault_q;
    logic             wait_state, wait_ready, tmo_hit;

    always_comb begin
        dec_cls     = C_R;
        dec_illegal = 1'b0;
        case (opcode_i)
            7'b0110011: begin
                if (funct7_i == 7'b0000001) begin
                    if (ENABLE_M) dec_cls = C_MULDIV;
                    else          dec_illegal = 1'b1;
                end
            end
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_illegal = 1'b1;
        endcase
    end

    // Ready/done only matter inside the state that is waiting for them.
    assign wait_state = (state_q == S_FETCH) || (state_q == S_MEM) || (state_q == S_MULDIV);
    assign wait_ready = (state_q == S_MULDIV) ? muldiv_done_i : mem_ready_i;
    assign tmo_hit    = (WAIT_TIMEOUT > 0) && (tmo_cnt_q == TMO_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cls_q       <= C_R;
            tmo_cnt_q   <= '0;
            illegal_q   <= 1'b0;
            bus_fault_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE) cls_q <= dec_cls;
            if (state_next != state_q) tmo_cnt_q <= '0;
            else if (wait_state)       tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (state_q == S_DECODE && dec_illegal) illegal_q <= 1'b1;
            if (wait_state && !wait_ready && tmo_hit) bus_fault_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  if (wait_ready) state_next = S_DECODE;
                      else if (tmo_hit) state_next = S_TRAP;
            S_DECODE: state_next = dec_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (cls_q)
                    C_LOAD, C_STORE: state_next = S_MEM;
                    C_BRANCH:        state_next = S_FETCH;
                    C_MULDIV:        state_next = S_MULDIV;
                    default:         state_next = S_WB;
                endcase
            end
            S_MEM:    if (wait_ready) state_next = (cls_q == C_LOAD) ? S_WB : S_FETCH;
                      else if (tmo_hit) state_next = S_TRAP;
            S_MULDIV: if (wait_ready) state_next = S_WB;
                      else if (tmo_hit) state_next = S_TRAP;
            S_WB:     state_next = S_FETCH;
            default:  state_next = S_TRAP;
        endcase
    end

    // NOTE: every output gets a default first so no path through the case can infer a latch.
    always_comb begin
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        iord_o         = 1'b0;
        ir_write_o     = 1'b0;
        pc_write_o     = 1'b0;
        reg_write_o    = 1'b0;
        alu_op_o       = 2'b00;
        alu_src_o      = 1'b0;
        mem_to_reg_o   = 1'b0;
        branch_o       = 1'b0;
        jump_o         = 1'b0;
        jalr_o         = 1'b0;
        lui_o          = 1'b0;
        auipc_o        = 1'b0;
        muldiv_start_o = 1'b0;

        // Class controls stay stable from EXEC through WB for the shared datapath.
        if (state_q inside {S_EXEC, S_MEM, S_MULDIV, S_WB}) begin
            case (cls_q)
                C_R:     alu_op_o = 2'b10;
                C_I:     begin alu_src_o = 1'b1; alu_op_o = 2'b11; end
                C_LOAD:  begin alu_src_o = 1'b1; mem_to_reg_o = 1'b1; end
                C_STORE: alu_src_o = 1'b1;
                C_JAL:   begin alu_src_o = 1'b1; jump_o = 1'b1; end
                C_JALR:  jalr_o = 1'b1;
                C_LUI:   begin alu_src_o = 1'b1; lui_o = 1'b1; end
                C_AUIPC: begin alu_src_o = 1'b1; auipc_o = 1'b1; end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req_o  = 1'b1;
                iord_o     = 1'b1;
                ir_write_o = mem_ready_i;
                pc_write_o = mem_ready_i;
            end
            S_EXEC: begin
                if (cls_q == C_BRANCH) begin
                    branch_o = 1'b1;
                    alu_op_o = 2'b01;
                end
                muldiv_start_o = (cls_q == C_MULDIV);
            end
            S_MEM: begin
                mem_req_o = 1'b1;
                mem_we_o  = (cls_q == C_STORE);
            end
            S_WB: begin
                reg_write_o = 1'b1;
                pc_write_o  = (cls_q == C_JAL) || (cls_q == C_JALR);
            end
            default: ;
        endcase
    end

    assign state_o     = state_q;
    assign illegal_o   = illegal_q;
    assign bus_fault_o = bus_fault_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: a per-class vector table plus hand sequences for
// wait states, timeout, trap, MUL/DIV and asynchronous reset.
module tb_multicycle_controller;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [6:0] opcode_i = 7'b0110011;
    logic [6:0] funct7_i = 7'b0;
    logic       mem_ready_i = 1'b1;
    logic       muldiv_done_i = 1'b1;

    // ctl: 15 mem_req 14 mem_we 13 iord 12 ir_write 11 pc_write 10 reg_write 9:8 alu_op
    //      7 alu_src 6 mem_to_reg 5 branch 4 jump 3 jalr 2 lui 1 auipc 0 muldiv_start
    logic [2:0]  st, t_st, n_st;
    logic [15:0] ctl, t_ctl, n_ctl;
    logic        ill, bf, t_ill, t_bf, n_ill, n_bf;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    multicycle_controller #(.ENABLE_M(1'b1), .WAIT_TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct7_i(funct7_i),
        .mem_ready_i(mem_ready_i), .muldiv_done_i(muldiv_done_i), .state_o(st),
        .mem_req_o(ctl[15]), .mem_we_o(ctl[14]), .iord_o(ctl[13]), .ir_write_o(ctl[12]),
        .pc_write_o(ctl[11]), .reg_write_o(ctl[10]), .alu_op_o(ctl[9:8]), .alu_src_o(ctl[7]),
        .mem_to_reg_o(ctl[6]), .branch_o(ctl[5]), .jump_o(ctl[4]), .jalr_o(ctl[3]),
        .lui_o(ctl[2]), .auipc_o(ctl[1]), .muldiv_start_o(ctl[0]),
        .illegal_o(ill), .bus_fault_o(bf));

    multicycle_controller #(.ENABLE_M(1'b1), .WAIT_TIMEOUT(4)) dut_t (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct7_i(funct7_i),
        .mem_ready_i(mem_ready_i), .muldiv_done_i(muldiv_done_i), .state_o(t_st),
        .mem_req_o(t_ctl[15]), .mem_we_o(t_ctl[14]), .iord_o(t_ctl[13]), .ir_write_o(t_ctl[12]),
        .pc_write_o(t_ctl[11]), .reg_write_o(t_ctl[10]), .alu_op_o(t_ctl[9:8]), .alu_src_o(t_ctl[7]),
        .mem_to_reg_o(t_ctl[6]), .branch_o(t_ctl[5]), .jump_o(t_ctl[4]), .jalr_o(t_ctl[3]),
        .lui_o(t_ctl[2]), .auipc_o(t_ctl[1]), .muldiv_start_o(t_ctl[0]),
        .illegal_o(t_ill), .bus_fault_o(t_bf));

    multicycle_controller #(.ENABLE_M(1'b0), .WAIT_TIMEOUT(64)) dut_n (
        .clk_i(clk_i), .rst_i(rst_i), .opcode_i(opcode_i), .funct7_i(funct7_i),
        .mem_ready_i(mem_ready_i), .muldiv_done_i(muldiv_done_i), .state_o(n_st),
        .mem_req_o(n_ctl[15]), .mem_we_o(n_ctl[14]), .iord_o(n_ctl[13]), .ir_write_o(n_ctl[12]),
        .pc_write_o(n_ctl[11]), .reg_write_o(n_ctl[10]), .alu_op_o(n_ctl[9:8]), .alu_src_o(n_ctl[7]),
        .mem_to_reg_o(n_ctl[6]), .branch_o(n_ctl[5]), .jump_o(n_ctl[4]), .jalr_o(n_ctl[3]),
        .lui_o(n_ctl[2]), .auipc_o(n_ctl[1]), .muldiv_start_o(n_ctl[0]),
        .illegal_o(n_ill), .bus_fault_o(n_bf));

    typedef struct {
        logic [6:0] op;
        logic [6:0] f7;
        int         cpi;
        logic [9:0] exec;  // {alu_op, alu_src, mem_to_reg, branch, jump, jalr, lui, auipc, start}
        logic [1:0] wb;    // {reg_write, pc_write} in WB
        logic       we;    // mem_we seen during the instruction
        string      name;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        mem_ready_i = 1'b1;
        muldiv_done_i = 1'b1;
        opcode_i = 7'b0110011;
        funct7_i = 7'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
    endtask

    logic [2:0] exp_seq [6];
    int         cyc, n, cnt2, guard;
    logic [9:0] exec_s;
    logic [1:0] wb_s;
    logic       we_s;

    initial begin
        vecs[0]  = '{7'b0110011, 7'b0000000, 4, 10'b10_0000_0000, 2'b10, 1'b0, "add"};
        vecs[1]  = '{7'b0110011, 7'b0100000, 4, 10'b10_0000_0000, 2'b10, 1'b0, "sub"};
        vecs[2]  = '{7'b0010011, 7'b0000000, 4, 10'b11_1000_0000, 2'b10, 1'b0, "opimm"};
        vecs[3]  = '{7'b0000011, 7'b0000000, 5, 10'b00_1100_0000, 2'b10, 1'b0, "load"};
        vecs[4]  = '{7'b0100011, 7'b0000000, 4, 10'b00_1000_0000, 2'b00, 1'b1, "store"};
        vecs[5]  = '{7'b1100011, 7'b0000000, 3, 10'b01_0010_0000, 2'b00, 1'b0, "branch"};
        vecs[6]  = '{7'b1101111, 7'b0000000, 4, 10'b00_1001_0000, 2'b11, 1'b0, "jal"};
        vecs[7]  = '{7'b1100111, 7'b0000000, 4, 10'b00_0000_1000, 2'b11, 1'b0, "jalr"};
        vecs[8]  = '{7'b0110111, 7'b0000000, 4, 10'b00_1000_0100, 2'b10, 1'b0, "lui"};
        vecs[9]  = '{7'b0010111, 7'b0000000, 4, 10'b00_1000_0010, 2'b10, 1'b0, "auipc"};
        vecs[10] = '{7'b0110011, 7'b0000001, 5, 10'b00_0000_0001, 2'b10, 1'b0, "mul"};
        exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};

        // Reset state and release.
        step();
        check("rst_state", st, 0);
        check("rst_ctl", ctl, 0);
        check("rst_flags", {ill, bf}, 0);
        rst_i = 1'b0;
        #1;
        check("rel_state", st, 0);

        // R-type state sequence after release.
        cnt2 = 0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("rseq%0d", i), st, exp_seq[i]);
            if (st == 3) check("rseq_aluop", ctl[9:8], 2'b10);
            cnt2 += ctl[10];
            if (i < 5) step();
        end
        check("rseq_regwrite_cycles", cnt2, 1);

        // Table: zero-wait instruction classes, starting each from FETCH.
        for (int v = 0; v < 11; v++) begin
            opcode_i = vecs[v].op;
            funct7_i = vecs[v].f7;
            check({vecs[v].name, "_fetch"}, ctl[15:11], 5'b10111);
            cyc = 1; exec_s = '0; wb_s = '0; we_s = ctl[14]; guard = 0;
            step();
            while (st != 3'd1 && guard < 20) begin
                cyc++; guard++;
                if (st == 3'd3) exec_s = ctl[9:0];
                if (st == 3'd5) wb_s = {ctl[10], ctl[11]};
                we_s |= ctl[14];
                step();
            end
            check({vecs[v].name, "_cpi"}, cyc, vecs[v].cpi);
            check({vecs[v].name, "_exec"}, exec_s, vecs[v].exec);
            check({vecs[v].name, "_wb"}, wb_s, vecs[v].wb);
            check({vecs[v].name, "_we"}, we_s, vecs[v].we);
        end

        // LOAD with memory not ready for three MEM cycles.
        do_reset(); step();
        opcode_i = 7'b0000011;
        step(); step();
        mem_ready_i = 1'b0;
        step();
        check("ldw_iord", ctl[13], 0);
        n = 0; cnt2 = 0;
        while (st == 3'd4 && n < 10) begin
            n++;
            cnt2 += ctl[15];
            if (n == 4) mem_ready_i = 1'b1;
            step();
        end
        check("ldw_mem_cycles", n, 4);
        check("ldw_req_cycles", cnt2, 4);
        check("ldw_wb_state", st, 5);
        check("ldw_wb_ctl", {ctl[10], ctl[6]}, 2'b11);

        // Asynchronous reset in the middle of MEM.
        do_reset(); step();
        opcode_i = 7'b0000011;
        step(); step();
        mem_ready_i = 1'b0;
        step();
        check("arst_pre_req", ctl[15], 1);
        #2 rst_i = 1'b1;
        #1;
        check("arst_req", ctl[15], 0);
        check("arst_state", st, 0);

        // Undefined opcode traps; flag sticky until reset.
        do_reset(); step();
        opcode_i = 7'h7F;
        step();
        check("ill_decode_flag", ill, 0);
        step();
        check("ill_state", st, 7);
        check("ill_flag", ill, 1);
        check("ill_ctl", ctl, 0);
        opcode_i = 7'b0110011;
        step(); step(); step();
        check("ill_hold", {st, ill}, {3'd7, 1'b1});
        rst_i = 1'b1;
        #1;
        check("ill_rst", {st, ill}, 4'd0);

        // Fetch timeout with WAIT_TIMEOUT=4.
        do_reset();
        mem_ready_i = 1'b0;
        step(); step(); step(); step();
        check("tmo_c4_state", t_st, 1);
        step();
        check("tmo_trap", t_st, 7);
        check("tmo_fault", t_bf, 1);
        check("tmo_trap_ctl", t_ctl, 0);
        check("tmo_main_wait", {st, bf}, {3'd1, 1'b0});

        // Ready in the last allowed cycle still completes.
        do_reset();
        mem_ready_i = 1'b0;
        step(); step(); step(); step();
        mem_ready_i = 1'b1;
        #1;
        check("tmo_last_irw", t_ctl[12], 1);
        step();
        check("tmo_last_state", t_st, 2);
        check("tmo_last_fault", t_bf, 0);

        // MUL/DIV with done in the fifth MULDIV cycle; ENABLE_M=0 instance traps.
        do_reset(); step();
        opcode_i = 7'b0110011;
        funct7_i = 7'b0000001;
        muldiv_done_i = 1'b0;
        cnt2 = 0;
        step();
        cnt2 += ctl[0];
        step();
        cnt2 += ctl[0];
        check("md_nom_trap", {n_st, n_ill}, {3'd7, 1'b1});
        step();
        n = 0;
        while (st == 3'd6 && n < 10) begin
            n++;
            cnt2 += ctl[0];
            if (n == 5) muldiv_done_i = 1'b1;
            step();
        end
        check("md_cycles", n, 5);
        check("md_start_pulses", cnt2, 1);
        check("md_wb", {st, ctl[10]}, {3'd5, 1'b1});
        check("md_tmo4_fault", {t_st, t_bf}, {3'd7, 1'b1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
